// File: rtl/axi_slave_read_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_slave_read_burst_ctrl: AXI read-burst sequencer, one beat per      |
// | 1-cycle-latency memory read, with external address-generator hookup.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module axi_slave_read_burst_ctrl #(
  parameter int ADDRESS_WIDTH          = 8,
  parameter int DATA_WIDTH             = 32,
  parameter int TRANSACTION_SIZE_BITS  = 3,
  parameter int TRANSACTION_BURST_BITS = 2,
  parameter int TRANSACTION_LEN_BITS   = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              ARVALID,
  output logic                              ARREADY,
  input  logic [ADDRESS_WIDTH-1:0]          ARADDR,
  input  logic [TRANSACTION_SIZE_BITS-1:0]  ARSIZE,
  input  logic [TRANSACTION_BURST_BITS-1:0] ARBURST,
  input  logic [TRANSACTION_LEN_BITS-1:0]   ARLEN,
  output logic                              RVALID,
  input  logic                              RREADY,
  output logic [DATA_WIDTH-1:0]             RDATA,
  output logic [1:0]                        RRESP,
  output logic                              RLAST,
  output logic                              MEM_RD_EN,
  output logic [ADDRESS_WIDTH-1:0]          MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]             MEM_RDATA,
  output logic [ADDRESS_WIDTH-1:0]          AG_LAST_ADDR,
  output logic [TRANSACTION_SIZE_BITS-1:0]  AG_SIZE,
  output logic [TRANSACTION_BURST_BITS-1:0] AG_BURST,
  output logic [TRANSACTION_LEN_BITS-1:0]   AG_LEN,
  input  logic [ADDRESS_WIDTH-1:0]          AG_NEXT_ADDR
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [TRANSACTION_BURST_BITS-1:0] BURST_WRAP = TRANSACTION_BURST_BITS'(2);
  localparam logic [TRANSACTION_BURST_BITS-1:0] BURST_RSVD = TRANSACTION_BURST_BITS'(3);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                              state_q, state_d;
  logic                                arready_q, arready_d;
  logic [ADDRESS_WIDTH-1:0]            addr_q, addr_d;
  logic [TRANSACTION_SIZE_BITS-1:0]    size_q, size_d;
  logic [TRANSACTION_BURST_BITS-1:0]   burst_q, burst_d;
  logic [TRANSACTION_LEN_BITS-1:0]     len_q, len_d;
  logic [TRANSACTION_LEN_BITS-1:0]     beat_cnt_q, beat_cnt_d;
  logic                                err_q, err_d;
  logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
  logic [1:0]                          rresp_q, rresp_d;

  logic wrap_len_ok;
  logic size_too_big;
  logic ar_err;
  logic last_beat;

  assign wrap_len_ok  = (ARLEN == TRANSACTION_LEN_BITS'(1)) || (ARLEN == TRANSACTION_LEN_BITS'(3)) ||
                        (ARLEN == TRANSACTION_LEN_BITS'(7)) || (ARLEN == TRANSACTION_LEN_BITS'(15));
  assign size_too_big = 32'(ARSIZE) > MAX_SIZE;
  assign ar_err       = (ARBURST == BURST_RSVD) || ((ARBURST == BURST_WRAP) && !wrap_len_ok) || size_too_big;
  assign last_beat    = (beat_cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    burst_d    = burst_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (state_q)
      S_IDLE: begin
        if (ARVALID && arready_q) begin
          addr_d     = ARADDR;
          size_d     = ARSIZE;
          burst_d    = ARBURST;
          len_d      = ARLEN;
          beat_cnt_d = '0;
          err_d      = ar_err;
          state_d    = S_RD;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        // An erroring burst never reads memory, so return zeros rather than stale bus data.
        rdata_d = err_q ? '0 : MEM_RDATA;
        rresp_d = err_q ? RESP_SLVERR : RESP_OKAY;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (RREADY) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + TRANSACTION_LEN_BITS'(1);
            addr_d     = AG_NEXT_ADDR;
            state_d    = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready tracks the next state, so it rises one cycle after reset or the last beat.
    arready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign ARREADY      = arready_q;
  assign RVALID       = (state_q == S_RESP);
  assign RLAST        = (state_q == S_RESP) && last_beat;
  assign RDATA        = rdata_q;
  assign RRESP        = rresp_q;
  assign MEM_RD_EN    = (state_q == S_RD) && !err_q;
  assign MEM_ADDR     = addr_q;
  assign AG_LAST_ADDR = addr_q;
  assign AG_SIZE      = size_q;
  assign AG_BURST     = burst_q;
  assign AG_LEN       = len_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_read_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axi_slave_read_burst_ctrl: directed bursts with queued expectations |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_axi_slave_read_burst_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  ARADDR = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [7:0]  ARLEN = '0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        MEM_RD_EN;
  logic [7:0]  MEM_ADDR;
  logic [31:0] MEM_RDATA = '0;
  logic [7:0]  AG_LAST_ADDR;
  logic [2:0]  AG_SIZE;
  logic [1:0]  AG_BURST;
  logic [7:0]  AG_LEN;
  logic [7:0]  AG_NEXT_ADDR;

  always #5 ACLK = ~ACLK;

  axi_slave_read_burst_ctrl dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .MEM_RD_EN(MEM_RD_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .AG_LAST_ADDR(AG_LAST_ADDR), .AG_SIZE(AG_SIZE), .AG_BURST(AG_BURST),
    .AG_LEN(AG_LEN), .AG_NEXT_ADDR(AG_NEXT_ADDR)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  r_exp_t     r_q[$];
  logic [7:0] m_q[$];
  logic [7:0] ea[$];

  function automatic logic [31:0] memfn(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Address generator model: FIXED holds, INCR steps aligned, WRAP wraps within the burst window.
  function automatic logic [7:0] agfn(input logic [7:0] a, input logic [2:0] s,
                                      input logic [1:0] b, input logic [7:0] l);
    logic [7:0] step, al, nx, wmask;
    int w;
    step = 8'(1 << s);
    al   = a & ~(step - 8'd1);
    nx   = al + step;
    w    = (int'(l) + 1) << s;
    wmask = 8'(w - 1);
    case (b)
      2'b00:   return a;
      2'b10:   return (al & ~wmask) | (nx & wmask);
      default: return nx;
    endcase
  endfunction

  always_comb AG_NEXT_ADDR = agfn(AG_LAST_ADDR, AG_SIZE, AG_BURST, AG_LEN);

  always @(posedge ACLK) if (MEM_RD_EN) MEM_RDATA <= memfn(MEM_ADDR);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a memory read or an R handshake.
  int   cyc = 0;
  int   last_evt = -1;
  bit   exp_idle = 0;
  logic prev_rvalid = 0;
  always @(negedge ACLK) begin
    r_exp_t e;
    cyc++;
    if (ARESET) begin
      m_q.delete();
      r_q.delete();
      last_evt    = -1;
      exp_idle    = 0;
      prev_rvalid = 0;
    end else begin
      if (exp_idle) begin
        chk("post_last_rvalid", 64'(RVALID), 64'd0);
        chk("post_last_arready", 64'(ARREADY), 64'd1);
        exp_idle = 0;
      end
      if (MEM_RD_EN) begin
        if (m_q.size() == 0) fail("unexpected_mem_rd");
        else chk("mem_addr", 64'(MEM_ADDR), 64'(m_q.pop_front()));
      end
      if (RVALID && !prev_rvalid && last_evt >= 0)
        chk("rvalid_latency", 64'(cyc - last_evt), 64'd3);
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) fail("unexpected_r_beat");
        else begin
          e = r_q.pop_front();
          chk("rdata", 64'(RDATA), 64'(e.data));
          chk("rresp", 64'(RRESP), 64'(e.resp));
          chk("rlast", 64'(RLAST), 64'(e.last));
        end
        last_evt = cyc;
        if (RLAST) begin
          exp_idle = 1;
          last_evt = -1;
        end
      end
      if (ARVALID && ARREADY) last_evt = cyc;
      prev_rvalid = RVALID;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arready"}, 64'(ARREADY), 64'd0);
    chk({tag, "_rvalid"}, 64'(RVALID), 64'd0);
    chk({tag, "_rlast"}, 64'(RLAST), 64'd0);
    chk({tag, "_rdata"}, 64'(RDATA), 64'd0);
    chk({tag, "_rresp"}, 64'(RRESP), 64'd0);
    chk({tag, "_mem_rd_en"}, 64'(MEM_RD_EN), 64'd0);
    chk({tag, "_mem_addr"}, 64'(MEM_ADDR), 64'd0);
  endtask

  // Expected beat addresses come from the global ea queue, filled by hand before each call.
  task automatic run_burst(input logic [7:0] a, input logic [2:0] s, input logic [1:0] b,
                           input logic [7:0] l, input bit err, input int stall_beat,
                           input int reset_beat);
    r_exp_t e;
    int n;
    logic [31:0] d0;
    logic [1:0]  r0;
    logic        l0;
    for (int i = 0; i <= int'(l); i++) begin
      if (!err) m_q.push_back(ea[i]);
      e.data = err ? 32'h0 : memfn(ea[i]);
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(l));
      r_q.push_back(e);
    end
    @(posedge ACLK); #1;
    ARVALID = 1'b1; ARADDR = a; ARSIZE = s; ARBURST = b; ARLEN = l;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!ARREADY && n < 50);
    if (!ARREADY) begin fail("arready_timeout"); ARVALID = 1'b0; return; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int beat = 0; beat <= int'(l); beat++) begin
      n = 0;
      do begin @(negedge ACLK); n++; end while (!RVALID && n < 20);
      if (!RVALID) begin fail("rvalid_timeout"); return; end
      if (beat == reset_beat) begin
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check_reset_outputs("midburst_reset");
        @(negedge ACLK);
        chk("reset_arready_back", 64'(ARREADY), 64'd1);
        return;
      end
      if (beat == stall_beat) begin
        d0 = RDATA; r0 = RRESP; l0 = RLAST;
        repeat (5) begin
          @(negedge ACLK);
          chk("stall_rvalid", 64'(RVALID), 64'd1);
          chk("stall_rdata", 64'(RDATA), 64'(d0));
          chk("stall_rresp", 64'(RRESP), 64'(r0));
          chk("stall_rlast", 64'(RLAST), 64'(l0));
          chk("stall_mem_rd_en", 64'(MEM_RD_EN), 64'd0);
        end
      end
      @(posedge ACLK); #1 RREADY = 1'b1;
      @(posedge ACLK); #1 RREADY = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("arready_first_cycle", 64'(ARREADY), 64'd0);
    @(negedge ACLK);
    chk("arready_rises", 64'(ARREADY), 64'd1);

    ea = '{8'h10, 8'h14, 8'h18, 8'h1C}; run_burst(8'h10, 3'd2, 2'b01, 8'd3, 1'b0, -1, -1);
    ea = '{8'h38, 8'h3C, 8'h30, 8'h34}; run_burst(8'h38, 3'd2, 2'b10, 8'd3, 1'b0, -1, -1);
    ea = '{8'h20, 8'h20, 8'h20};        run_burst(8'h20, 3'd2, 2'b00, 8'd2, 1'b0, -1, -1);
    ea = '{8'hFC, 8'h00};               run_burst(8'hFC, 3'd2, 2'b01, 8'd1, 1'b0, -1, -1);
    ea = '{8'h11, 8'h14};               run_burst(8'h11, 3'd2, 2'b01, 8'd1, 1'b0, -1, -1);
    ea = '{8'h40, 8'h44, 8'h48, 8'h4C}; run_burst(8'h40, 3'd2, 2'b01, 8'd3, 1'b0, 1, -1);
    ea = '{8'h50, 8'h54};               run_burst(8'h50, 3'd2, 2'b11, 8'd1, 1'b1, -1, -1);
    ea = '{8'h60, 8'h64, 8'h68};        run_burst(8'h60, 3'd2, 2'b10, 8'd2, 1'b1, -1, -1);
    ea = '{8'h70, 8'h78};               run_burst(8'h70, 3'd3, 2'b01, 8'd1, 1'b1, -1, -1);
    ea = '{8'h80, 8'h84, 8'h88, 8'h8C}; run_burst(8'h80, 3'd2, 2'b01, 8'd3, 1'b0, -1, 1);
    ea = '{8'h90, 8'h94};               run_burst(8'h90, 3'd2, 2'b01, 8'd1, 1'b0, -1, -1);

    repeat (5) @(negedge ACLK);
    chk("r_queue_drained", 64'(r_q.size()), 64'd0);
    chk("mem_queue_drained", 64'(m_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
